sensor_matrix_scanner: RTL

//  Scans the 8x4 reed-switch matrix under the 32 dark squares. Debounces each square and the player button.

---
 rtl/checkers_io_pkg.sv | 21 ++
 rtl/sync_debounce.sv | 52 +++++
 rtl/sensor_matrix_scanner.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/checkers_io_pkg.sv
// Shared definitions for the checkers-board I/O blocks.
//   NUM_ROWS / NUM_COLS / NUM_SQUARES : geometry of the dark-square reed-switch matrix
//   scan_state_t                      : encoding of the row-scan FSM
//   sq_index(row, col)                : bit position of a square in the sensor-board word
package checkers_io_pkg;

  localparam int NUM_ROWS    = 8;
  localparam int NUM_COLS    = 4;
  localparam int NUM_SQUARES = NUM_ROWS * NUM_COLS;

  typedef enum logic {
    ST_DRIVE  = 1'b0,
    ST_SAMPLE = 1'b1
  } scan_state_t;

  // row*4+col; with four columns this is plain bit concatenation.
  function automatic logic [4:0] sq_index(input logic [2:0] row, input logic [1:0] col);
    return {row, col};
  endfunction

endpackage

// File: rtl/sync_debounce.sv
// Two-flop synchronizer plus stability filter for one active-low async input.
//   clock  : system clock
//   reset  : synchronous active-low reset
//   raw_n  : asynchronous input, 0 = asserted
//   level  : accepted (debounced) level, active-high
//   rise   : one-cycle pulse in the cycle a 0->1 change of level is accepted
// A change is accepted once the synced level has differed from the accepted
// level for CYCLES consecutive cycles; any return to the accepted level
// restarts the count.
module sync_debounce #(
  parameter int CYCLES = 250000
) (
  input  logic clock,
  input  logic reset,
  input  logic raw_n,
  output logic level,
  output logic rise
);

  localparam int CW = (CYCLES > 1) ? $clog2(CYCLES) : 1;

  logic          sync1;
  logic          sync2;
  logic [CW-1:0] stable_cnt;
  logic          accept;

  assign accept = (sync2 != level) && (stable_cnt == CW'(CYCLES - 1));
  assign rise   = accept && sync2;

  // NOTE: every flop in a clocked block is assigned with <= so all of them
  // sample pre-edge values; blocking = here would turn sync2 <= sync1 into a wire.
  always_ff @(posedge clock) begin
    if (!reset) begin
      sync1      <= 1'b0;
      sync2      <= 1'b0;
      level      <= 1'b0;
      stable_cnt <= '0;
    end else begin
      sync1 <= ~raw_n;
      sync2 <= sync1;
      if (sync2 == level) begin
        stable_cnt <= '0;
      end else if (accept) begin
        level      <= sync2;
        stable_cnt <= '0;
      end else begin
        stable_cnt <= stable_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/sensor_matrix_scanner.sv
// Scans the 8x4 reed-switch matrix under the dark squares, debounces every
// square and the player button, and presents the results to the memory manager.
//   clock         : system clock
//   reset         : synchronous active-low reset
//   row_drive_n   : one-hot active-low row strobe (8'hFF while idle in reset)
//   col_sense_n   : asynchronous column returns, 0 = piece present
//   button_n      : asynchronous push-button, 0 = pressed
//   button_ack    : one-cycle pulse, CPU consumed the press
//   sensor_board  : debounced occupancy, bit row*4+col
//   board_valid   : high once DEBOUNCE_SCANS full frames have completed
//   board_changed : one-cycle pulse after a frame in which any bit flipped
//   button_press  : sticky press flag, cleared by button_ack
module sensor_matrix_scanner
  import checkers_io_pkg::*;
#(
  parameter int SETTLE_CYCLES       = 64,
  parameter int DEBOUNCE_SCANS      = 4,
  parameter int BTN_DEBOUNCE_CYCLES = 250000
) (
  input  logic        clock,
  input  logic        reset,
  output logic [7:0]  row_drive_n,
  input  logic [3:0]  col_sense_n,
  input  logic        button_n,
  input  logic        button_ack,
  output logic [31:0] sensor_board,
  output logic        board_valid,
  output logic        board_changed,
  output logic        button_press
);

  localparam int SW = $clog2(SETTLE_CYCLES);
  localparam int DW = $clog2(DEBOUNCE_SCANS + 1);

  // Scan FSM
  scan_state_t state, state_nxt;
  logic [SW-1:0] settle_cnt, settle_cnt_nxt;
  logic [2:0]    row, row_nxt;
  // Low in the first cycle after reset so row 0 gets its full settle time.
  logic          scan_en;

  // Matrix debounce
  logic [3:0]    col_s1, col_s2;
  logic [DW-1:0] deb_cnt [NUM_SQUARES];
  logic [DW-1:0] deb_nxt [NUM_SQUARES];
  logic [31:0]   board_nxt;
  logic [4:0]    sq;
  logic          any_flip;
  logic          flip_seen;
  logic          sample_now;
  logic          frame_end;
  logic [DW-1:0] frame_cnt;

  // Button
  logic          btn_level;
  logic          btn_rise;

  assign sample_now = scan_en && (state == ST_SAMPLE);
  assign frame_end  = sample_now && (row == 3'd7);

  always_ff @(posedge clock) begin
    if (!reset) begin
      scan_en    <= 1'b0;
      state      <= ST_DRIVE;
      settle_cnt <= '0;
      row        <= '0;
    end else begin
      scan_en <= 1'b1;
      if (scan_en) begin
        state      <= state_nxt;
        settle_cnt <= settle_cnt_nxt;
        row        <= row_nxt;
      end
    end
  end

  // NOTE: every signal written here gets a default before the case, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    state_nxt      = state;
    settle_cnt_nxt = settle_cnt;
    row_nxt        = row;
    row_drive_n    = scan_en ? ~(8'd1 << row) : 8'hFF;
    case (state)
      ST_DRIVE: begin
        if (settle_cnt == SW'(SETTLE_CYCLES - 1)) begin
          state_nxt      = ST_SAMPLE;
          settle_cnt_nxt = '0;
        end else begin
          settle_cnt_nxt = settle_cnt + 1'b1;
        end
      end
      ST_SAMPLE: begin
        state_nxt = ST_DRIVE;
        row_nxt   = row + 3'd1;  // 3-bit wrap 7 -> 0 starts the next frame
      end
      default: state_nxt = ST_DRIVE;
    endcase
  end

  // Per-square debounce: only the four squares of the driven row move, and
  // only in the SAMPLE cycle.
  always_comb begin
    board_nxt = sensor_board;
    any_flip  = 1'b0;
    sq        = '0;
    for (int s = 0; s < NUM_SQUARES; s++) deb_nxt[s] = deb_cnt[s];
    if (sample_now) begin
      for (int c = 0; c < NUM_COLS; c++) begin
        sq = sq_index(row, 2'(c));
        if (col_s2[c] == sensor_board[sq]) begin
          deb_nxt[sq] = '0;
        end else if (deb_cnt[sq] == DW'(DEBOUNCE_SCANS - 1)) begin
          board_nxt[sq] = ~sensor_board[sq];
          deb_nxt[sq]   = '0;
          any_flip      = 1'b1;
        end else begin
          deb_nxt[sq] = deb_cnt[sq] + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      col_s1        <= '0;
      col_s2        <= '0;
      sensor_board  <= '0;
      flip_seen     <= 1'b0;
      board_changed <= 1'b0;
      frame_cnt     <= '0;
      board_valid   <= 1'b0;
      // NOTE: the counter array is reset with the rest because a mid-scan reset
      // must not let a half-finished debounce carry over into the new scan.
      for (int s = 0; s < NUM_SQUARES; s++) deb_cnt[s] <= '0;
    end else begin
      col_s1       <= ~col_sense_n;
      col_s2       <= col_s1;
      sensor_board <= board_nxt;
      for (int s = 0; s < NUM_SQUARES; s++) deb_cnt[s] <= deb_nxt[s];
      board_changed <= frame_end && (flip_seen || any_flip);
      flip_seen     <= frame_end ? 1'b0 : (flip_seen || any_flip);
      if (frame_end && (frame_cnt != DW'(DEBOUNCE_SCANS))) begin
        frame_cnt <= frame_cnt + 1'b1;
        if (frame_cnt == DW'(DEBOUNCE_SCANS - 1)) board_valid <= 1'b1;
      end
    end
  end

  sync_debounce #(
    .CYCLES (BTN_DEBOUNCE_CYCLES)
  ) u_button (
    .clock (clock),
    .reset (reset),
    .raw_n (button_n),
    .level (btn_level),
    .rise  (btn_rise)
  );

  // A press accepted in the same cycle as an ack wins over the clear.
  always_ff @(posedge clock) begin
    if (!reset) begin
      button_press <= 1'b0;
    end else if (btn_rise) begin
      button_press <= 1'b1;
    end else if (button_ack) begin
      button_press <= 1'b0;
    end
  end

endmodule
